// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into an APB SETUP/ACCESS transfer with a one-cycle response pulse.
// Optional ACCESS-phase timeout abort is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [7:0]  PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [7:0]  paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("apb_master: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             expired;

  // True on the last permitted ACCESS cycle; PREADY on that cycle still wins.
  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d  = SETUP;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (PREADY) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (expired) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Handshake/strobe flops are derived from the next state so they line up with it.
    cmd_ready_d = (state_d == IDLE);
    psel_d      = (state_d != IDLE);
    penable_d   = (state_d == ACCESS);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: a memory-backed APB slave model with random wait states,
// phase-by-phase protocol expectations, reset abort and timeout scenarios.
module tb_apb_master;

  localparam int unsigned TO = 16;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem [256];
  logic [31:0] last_rdata;

  apb_master #(.TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic junk_cmd();
    cmd_write = 1'($urandom);
    cmd_addr  = 8'($urandom);
    cmd_wdata = $urandom;
  endtask

  task automatic check_bus(input string ph, input int sel, input int en,
                           input logic wr, input logic [7:0] a, input logic [31:0] wd);
    check({ph, "_psel"},      32'(PSEL), 32'(sel));
    check({ph, "_penable"},   32'(PENABLE), 32'(en));
    check({ph, "_paddr"},     32'(PADDR), 32'(a));
    check({ph, "_pwrite"},    32'(PWRITE), 32'(wr));
    check({ph, "_pwdata"},    PWDATA, wd);
    check({ph, "_cmd_ready"}, 32'(cmd_ready), 0);
    check({ph, "_rsp_valid"}, 32'(rsp_valid), 0);
  endtask

  // One complete transfer; returns positioned in the response cycle.
  task automatic do_xfer(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                         input int unsigned waits, input logic hold);
    logic [31:0] exp_rd;
    check("accept_ready", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    tick();
    cmd_valid = hold;
    junk_cmd();
    check_bus("setup", 1, 0, wr, a, wd);
    PREADY = 1'($urandom);
    PRDATA = $urandom;
    tick();
    for (int unsigned i = 0; i <= waits; i++) begin
      check_bus("access", 1, 1, wr, a, wd);
      PREADY = (i == waits);
      PRDATA = (i == waits && !wr) ? mem[a] : $urandom;
      tick();
    end
    exp_rd = wr ? 32'h0 : mem[a];
    check("rsp_valid",   32'(rsp_valid), 1);
    check("rsp_timeout", 32'(rsp_timeout), 0);
    check("rsp_rdata",   rsp_rdata, exp_rd);
    check("rsp_psel",    32'(PSEL), 0);
    check("rsp_penable", 32'(PENABLE), 0);
    check("rsp_paddr",   32'(PADDR), 32'(a));
    check("rsp_pwdata",  PWDATA, wd);
    last_rdata = rsp_rdata;
    if (wr) mem[a] = wd;
    PREADY = 1'($urandom);
    PRDATA = $urandom;
  endtask

  task automatic idle(input int unsigned n);
    cmd_valid = 1'b0;
    junk_cmd();
    repeat (n) begin
      tick();
      check("idle_rsp_valid", 32'(rsp_valid), 0);
      check("idle_psel",      32'(PSEL), 0);
      check("idle_penable",   32'(PENABLE), 0);
      check("idle_cmd_ready", 32'(cmd_ready), 1);
      PREADY = 1'($urandom);
    end
  endtask

  task automatic reset_mid_access();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h33;
    cmd_wdata = $urandom;
    tick();
    cmd_valid = 1'b0;
    PREADY = 1'b0;
    tick();
    check("rst_pre_penable", 32'(PENABLE), 1);
    PREADY = 1'b0;
    #3 PRESET = 1'b1;
    #1;
    check("rst_async_psel",      32'(PSEL), 0);
    check("rst_async_penable",   32'(PENABLE), 0);
    check("rst_async_cmd_ready", 32'(cmd_ready), 0);
    check("rst_async_rsp_valid", 32'(rsp_valid), 0);
    tick();
    check("rst_hold_rsp_valid", 32'(rsp_valid), 0);
    PRESET = 1'b0;
    check("rst_rel_cmd_ready", 32'(cmd_ready), 0);
    tick();
    check("rst_post_cmd_ready", 32'(cmd_ready), 1);
    check("rst_post_rsp_valid", 32'(rsp_valid), 0);
    check("rst_post_psel",      32'(PSEL), 0);
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic do_timeout(input logic [7:0] a);
    check("to_accept_ready", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = a;
    cmd_wdata = $urandom;
    tick();
    cmd_valid = 1'b0;
    check("to_setup_penable", 32'(PENABLE), 0);
    PREADY = 1'b0;
    tick();
    for (int unsigned i = 0; i < TO; i++) begin
      check("to_access_psel",    32'(PSEL), 1);
      check("to_access_penable", 32'(PENABLE), 1);
      check("to_access_rsp",     32'(rsp_valid), 0);
      PREADY = 1'b0;
      PRDATA = $urandom;
      tick();
    end
    check("to_rsp_valid",   32'(rsp_valid), 1);
    check("to_rsp_timeout", 32'(rsp_timeout), 1);
    check("to_rsp_rdata",   rsp_rdata, 0);
    check("to_psel",        32'(PSEL), 0);
    check("to_penable",     32'(PENABLE), 0);
    check("to_cmd_ready",   32'(cmd_ready), 1);
  endtask
`endif

  initial begin
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    junk_cmd();
    PREADY    = 1'b0;
    PRDATA    = '0;
    last_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    repeat (2) tick();
    check("reset_psel",        32'(PSEL), 0);
    check("reset_penable",     32'(PENABLE), 0);
    check("reset_pwrite",      32'(PWRITE), 0);
    check("reset_paddr",       32'(PADDR), 0);
    check("reset_pwdata",      PWDATA, 0);
    check("reset_rsp_valid",   32'(rsp_valid), 0);
    check("reset_rsp_rdata",   rsp_rdata, 0);
    check("reset_rsp_timeout", 32'(rsp_timeout), 0);
    check("reset_cmd_ready",   32'(cmd_ready), 0);
    PRESET = 1'b0;
    check("release_cmd_ready", 32'(cmd_ready), 0);
    tick();
    check("first_edge_cmd_ready", 32'(cmd_ready), 1);

    do_xfer(1'b1, 8'h10, 32'hDEADBEEF, 1, 1'b0);
    check("wr_rdata_zero", last_rdata, 0);
    idle(1);
    do_xfer(1'b0, 8'h10, $urandom, 0, 1'b0);
    check("rd_back_deadbeef", last_rdata, 32'hDEADBEEF);
    idle(2);

    do_xfer(1'b1, 8'h01, $urandom, 0, 1'b1);
    do_xfer(1'b1, 8'h02, $urandom, 0, 1'b0);
    idle(1);

    reset_mid_access();
    do_xfer(1'b0, 8'h33, $urandom, 2, 1'b0);
    idle(1);

    do_xfer(1'b1, 8'h44, $urandom, TO - 1, 1'b0);
    idle(1);
    do_xfer(1'b0, 8'h44, $urandom, TO - 1, 1'b0);
    idle(1);

`ifdef APB_MASTER_TIMEOUT_EN
    do_timeout(8'h55);
    idle(1);
    do_xfer(1'b0, 8'h55, $urandom, 0, 1'b0);
    idle(1);
`endif

    for (int n = 0; n < 60; n++) begin
      logic hold;
      hold = 1'($urandom);
      do_xfer(1'($urandom), 8'($urandom_range(7, 0)), $urandom, $urandom_range(5, 0), hold);
      if (!hold) idle($urandom_range(2, 0));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: max ACCESS-phase cycles before abort; used only when APB_MASTER_TIMEOUT_EN is defined.
REQ-002 SHALL have port PCLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port PRESET  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a rising edge.
REQ-006 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr  input  8  target address.
REQ-008 SHALL have port cmd_wdata  input  32  write data.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata  output  32  read data; valid with rsp_valid.
REQ-011 SHALL have port rsp_timeout  output  1  transfer aborted; valid with rsp_valid.
REQ-012 SHALL have ports PSEL, PENABLE, PWRITE (output, 1), PADDR (output, 8), PWDATA (output, 32), PRDATA (input, 32), PREADY (input, 1): APB requester side.

Function
REQ-013 SHALL implement states IDLE, SETUP, ACCESS; all outputs registered.
REQ-014 SHALL drive cmd_ready=1 only in IDLE; command fields latched on acceptance; cmd fields ignored otherwise.
REQ-015 SHALL move IDLE->SETUP on acceptance; in SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = latched command.
REQ-016 SHALL move SETUP->ACCESS unconditionally after one cycle; in ACCESS: PSEL=1, PENABLE=1, PADDR/PWRITE/PWDATA held stable.
REQ-017 SHALL remain in ACCESS while PREADY=0 (wait states, unbounded unless timeout enabled).
REQ-018 SHALL, on a rising edge in ACCESS with PREADY=1: capture PRDATA into rsp_rdata for reads (rsp_rdata=0 for writes), set rsp_valid=1 and rsp_timeout=0 for the next cycle, return to IDLE.
REQ-019 SHALL deassert PSEL and PENABLE in IDLE; PADDR/PWRITE/PWDATA hold last values in IDLE.
REQ-020 SHALL hold rsp_valid high for exactly one cycle per transfer; no response backpressure.
REQ-021 SHALL allow a new command accepted in the cycle rsp_valid is high (minimum 3 cycles per transfer, acceptance to acceptance, zero wait states).
REQ-022 SHALL ignore PREADY outside ACCESS.

Reset
REQ-023 SHALL, while PRESET=1, force state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, cmd_ready=0; cmd_ready=1 from first edge after release.
REQ-024 SHALL abandon any in-flight transfer on reset without issuing rsp_valid.

Configuration
REQ-025 SHALL, with APB_MASTER_TIMEOUT_EN defined, count ACCESS cycles (counter cleared on SETUP->ACCESS); if TIMEOUT_CYCLES ACCESS cycles elapse with PREADY=0, go to IDLE, drop PSEL/PENABLE, pulse rsp_valid with rsp_timeout=1, rsp_rdata=0.
REQ-026 SHALL give PREADY=1 on the final counted cycle priority over timeout (normal completion).
REQ-027 SHALL, without APB_MASTER_TIMEOUT_EN, omit the counter, tie rsp_timeout=0, wait in ACCESS indefinitely.

Verification
REQ-028 Write 0xDEADBEEF to 0x10, slave PREADY after 1 wait -> SETUP 1 cycle, ACCESS 2 cycles, PWDATA stable, rsp_valid one cycle, rsp_rdata=0.
REQ-029 Read 0x10 after write, zero wait states -> rsp_rdata=0xDEADBEEF, rsp_timeout=0, cmd_ready low during SETUP/ACCESS.
REQ-030 Back-to-back writes 0x01/0x02 with cmd_valid held high -> second accepted in rsp_valid cycle, PSEL low exactly one cycle between transfers.
REQ-031 Assert PRESET mid-ACCESS -> PSEL/PENABLE low immediately (async), no rsp_valid, next command completes normally.
REQ-032 With APB_MASTER_TIMEOUT_EN, PREADY held 0 -> after 16 ACCESS cycles rsp_valid=1, rsp_timeout=1, PSEL=0; PREADY=1 on 16th cycle -> normal completion, rsp_timeout=0.
